// File: rtl/vga_timing_gen_if.sv
// Timing bus between the VGA timing source and the drawing pipeline.
// The source drives it through the "out" modport; drawing stages read it through "in".
interface vga_if_tim;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing source: 11-bit h/v counters with a pixel enable, registered sync/blank decode,
// a frame-start strobe and a free-running completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if_tim.out      tim_if_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..2048");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  // 12-bit window bounds so a sync pulse ending exactly at 2048 still compares correctly
  localparam logic [11:0] HB_BEG   = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VB_BEG   = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q;
  logic [10:0] vcount_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        hblnk_q;
  logic        vblnk_q;

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        frame_wrap;
  logic        hsync_next;
  logic        vsync_next;
  logic        hblnk_next;
  logic        vblnk_next;

  always_comb begin
    h_next     = hcount_q + 11'd1;
    v_next     = vcount_q;
    frame_wrap = 1'b0;
    if (hcount_q >= H_LAST) begin
      h_next = '0;
      if (vcount_q >= V_LAST) begin
        v_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        v_next = vcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next count so they register together with it.
  always_comb begin
    hblnk_next = {1'b0, h_next} >= HB_BEG;
    vblnk_next = {1'b0, v_next} >= VB_BEG;
    hsync_next = (({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END)) ~^ HS_POL;
    vsync_next = (({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END)) ~^ VS_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hcount_q    <= h_next;
      vcount_q    <= v_next;
      hblnk_q     <= hblnk_next;
      vblnk_q     <= vblnk_next;
      hsync_q     <= hsync_next;
      vsync_q     <= vsync_next;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign tim_if_out.hcount = hcount_q;
  assign tim_if_out.vcount = vcount_q;
  assign tim_if_out.hsync  = hsync_q;
  assign tim_if_out.vsync  = vsync_q;
  assign tim_if_out.hblnk  = hblnk_q;
  assign tim_if_out.vblnk  = vblnk_q;

endmodule
